// File: rtl/rvv_vd_collector.sv
`default_nettype none
// ============================================================================
//  Module   : rvv_vd_collector
//  Purpose  : Collects per-lane vector results into one destination register
//             image. Bits that are not written keep their vd_old value. The
//             finished image is offered to the register-file write port.
//  Revision : 1.0 - initial release
// ============================================================================
module rvv_vd_collector #(
   parameter int VLEN     = 128,
   parameter int NB_LANES = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      start,
   input  logic [VLEN-1:0]           vd_old,
   input  logic [2:0]                vsew,
   input  logic [(64<<NB_LANES)-1:0] lane_vd,
   input  logic [(10<<NB_LANES)-1:0] lane_idx,
   input  logic [(1<<NB_LANES)-1:0]  lane_valid,
   input  logic                      alu_done,
   input  logic                      wb_ready,
   output logic [VLEN-1:0]           vd_out,
   output logic                      wb_valid,
   output logic                      busy,
   output logic                      idx_err
);

   localparam int          c_LANES = 1 << NB_LANES;
   localparam logic [10:0] c_VLEN  = 11'(VLEN);

   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_COLLECT = 2'd1;
   localparam logic [1:0] c_ST_WB      = 2'd2;

   logic [1:0]                      r_state;
   logic [VLEN-1:0]                 r_buf;
   logic                            r_idx_err;

   logic [63:0]                     w_elem_mask;
   logic [c_LANES-1:0][VLEN-1:0]    w_lane_mask;
   logic [c_LANES-1:0][VLEN-1:0]    w_lane_data;
   logic [c_LANES-1:0]              w_oob;
   logic [VLEN-1:0]                 w_buf_next;

   // Element-width mask; any vsew above 3 is treated as a 64-bit element.
   always_comb begin
      w_elem_mask = '1;
      case (vsew)
         3'd0:    w_elem_mask = 64'h0000_0000_0000_00FF;
         3'd1:    w_elem_mask = 64'h0000_0000_0000_FFFF;
         3'd2:    w_elem_mask = 64'h0000_0000_FFFF_FFFF;
         default: w_elem_mask = '1;
      endcase
   end

   // Per lane: place the element mask and data at the destination offset.
   // Bits shifted past VLEN fall off the top; an out-of-range offset writes
   // nothing and is flagged instead.
   generate
      for (genvar k = 0; k < c_LANES; k++) begin : g_lane
         logic [9:0] w_idx;
         logic       w_in_range;

         assign w_idx          = lane_idx[10*k +: 10];
         assign w_in_range     = ({1'b0, w_idx} < c_VLEN);
         assign w_oob[k]       = lane_valid[k] && !w_in_range;
         assign w_lane_mask[k] = (lane_valid[k] && w_in_range)
                                 ? (VLEN'(w_elem_mask) << w_idx) : '0;
         assign w_lane_data[k] = VLEN'(lane_vd[64*k +: 64] & w_elem_mask) << w_idx;
      end
   endgenerate

   // Merge lane writes in ascending lane order so the highest lane wins overlaps.
   always_comb begin
      w_buf_next = r_buf;
      for (int k = 0; k < c_LANES; k++) begin
         w_buf_next = (w_buf_next & ~w_lane_mask[k]) | (w_lane_data[k] & w_lane_mask[k]);
      end
   end

   // Control FSM, buffer and sticky index error; start reloads from vd_old.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= c_ST_IDLE;
         r_buf     <= '0;
         r_idx_err <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (start) begin
                  r_buf     <= vd_old;
                  r_idx_err <= 1'b0;
                  r_state   <= c_ST_COLLECT;
               end
            end
            c_ST_COLLECT: begin
               if (start) begin
                  r_buf     <= vd_old;
                  r_idx_err <= 1'b0;
               end else begin
                  r_buf <= w_buf_next;
                  if (|w_oob) begin
                     r_idx_err <= 1'b1;
                  end
                  if (alu_done) begin
                     r_state <= c_ST_WB;
                  end
               end
            end
            c_ST_WB: begin
               if (wb_ready) begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers; no path from the lane inputs.
   assign vd_out   = r_buf;
   assign wb_valid = (r_state == c_ST_WB);
   assign busy     = (r_state != c_ST_IDLE);
   assign idx_err  = r_idx_err;

endmodule
`default_nettype wire

// File: tb/tb_rvv_vd_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvv_vd_collector
//  Purpose  : Self-checking bench for rvv_vd_collector (VLEN=128, 2 lanes):
//             directed scenarios followed by random transactions, all
//             compared every cycle against a bit-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rvv_vd_collector;

   localparam int VLEN = 128;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [127:0]  vd_old;
   logic [2:0]    vsew;
   logic [127:0]  lane_vd;
   logic [19:0]   lane_idx;
   logic [1:0]    lane_valid;
   logic          alu_done;
   logic          wb_ready;
   logic [127:0]  vd_out;
   logic          wb_valid;
   logic          busy;
   logic          idx_err;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: 0 = idle, 1 = collecting, 2 = waiting for write-back
   logic [127:0]  m_buf = '0;
   logic          m_err = 1'b0;
   int            m_st  = 0;

   rvv_vd_collector #(.VLEN(128), .NB_LANES(1)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .vd_old     (vd_old),
      .vsew       (vsew),
      .lane_vd    (lane_vd),
      .lane_idx   (lane_idx),
      .lane_valid (lane_valid),
      .alu_done   (alu_done),
      .wb_ready   (wb_ready),
      .vd_out     (vd_out),
      .wb_valid   (wb_valid),
      .busy       (busy),
      .idx_err    (idx_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".vd_out"},   vd_out,                   m_buf);
      chk({tag, ".busy"},     128'(busy),               128'(m_st != 0));
      chk({tag, ".wb_valid"}, 128'(wb_valid),           128'(m_st == 2));
      chk({tag, ".idx_err"},  128'(idx_err),            128'(m_err));
   endtask

   // Apply this cycle's lane writes bit by bit, lane 0 first so lane 1 wins.
   task automatic model_writes();
      int w;
      int idx;
      w = (vsew >= 3'd3) ? 64 : (8 << vsew);
      for (int k = 0; k < 2; k++) begin
         if (lane_valid[k]) begin
            idx = int'(lane_idx[10*k +: 10]);
            if (idx >= VLEN) begin
               m_err = 1'b1;
            end else begin
               for (int b = 0; b < w; b++) begin
                  if (idx + b < VLEN) m_buf[idx + b] = lane_vd[64*k + b];
               end
            end
         end
      end
   endtask

   task automatic model_edge();
      case (m_st)
         0: if (start) begin m_buf = vd_old; m_err = 1'b0; m_st = 1; end
         1: begin
            if (start) begin
               m_buf = vd_old;
               m_err = 1'b0;
            end else begin
               model_writes();
               if (alu_done) m_st = 2;
            end
         end
         2: if (wb_ready) m_st = 0;
         default: m_st = 0;
      endcase
   endtask

   // One clock: advance the model, take the edge, check everything.
   task automatic cyc(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic quiet();
      start      = 1'b0;
      lane_valid = 2'b00;
      alu_done   = 1'b0;
      wb_ready   = 1'b0;
   endtask

   task automatic beat(input logic [1:0] v, input logic [9:0] i0, input logic [9:0] i1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic done,
                       input string tag);
      start      = 1'b0;
      lane_valid = v;
      lane_idx   = {i1, i0};
      lane_vd    = {d1, d0};
      alu_done   = done;
      cyc(tag);
   endtask

   task automatic do_start(input logic [2:0] sew, input logic [127:0] old, input string tag);
      quiet();
      vsew   = sew;
      vd_old = old;
      start  = 1'b1;
      cyc(tag);
      start  = 1'b0;
   endtask

   task automatic release_wb(input string tag);
      quiet();
      wb_ready = 1'b1;
      cyc(tag);
      wb_ready = 1'b0;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] exp;
      logic [127:0] saved;
      logic [63:0]  d0;
      logic [63:0]  d1;
      logic [3:0]   nib;
      int           nb;

      resetn   = 1'b0;
      vd_old   = '0;
      vsew     = 3'd0;
      lane_vd  = '0;
      lane_idx = '0;
      quiet();
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset");
      resetn = 1'b1;

      // Byte-wise assembly over 8 beats on top of an all-ones background
      do_start(3'd0, '1, "r33_start");
      exp = '0;
      for (int i = 0; i < 8; i++) begin
         nib = 4'(i);
         d0 = rnd64(); d0[7:0] = {nib, 4'h0};
         d1 = rnd64(); d1[7:0] = {nib, 4'h1};
         exp[16*i +: 8]     = {nib, 4'h0};
         exp[16*i + 8 +: 8] = {nib, 4'h1};
         beat(2'b11, 10'(16*i), 10'(16*i + 8), d0, d1, (i == 7), "r33_beat");
      end
      chk("r33_bytes", vd_out, exp);
      chk("r33_wb_valid", 128'(wb_valid), 128'(1));
      release_wb("r33_release");

      // Full 64-bit elements from both lanes
      do_start(3'd3, '0, "r34_start");
      beat(2'b11, 10'd0, 10'd64, 64'hDEADBEEF_01234567, 64'hCAFEF00D_89ABCDEF, 1'b1, "r34_beat");
      chk("r34_value", vd_out, 128'hCAFEF00D_89ABCDEF_DEADBEEF_01234567);
      release_wb("r34_release");

      // Single 16-bit write, all other bits undisturbed
      do_start(3'd1, '1, "r35_start");
      d0 = rnd64(); d0[15:0] = 16'h1234;
      beat(2'b01, 10'd32, 10'd0, d0, rnd64(), 1'b1, "r35_beat");
      chk("r35_value", vd_out, 128'hFFFFFFFF_FFFFFFFF_FFFF1234_FFFFFFFF);
      release_wb("r35_release");

      // Overlap priority, then an out-of-range write
      do_start(3'd0, '0, "r36_start");
      beat(2'b11, 10'd8, 10'd8, 64'h00000000_000000AA, 64'h00000000_000000BB, 1'b0, "r36_overlap");
      chk("r36_overlap_value", vd_out, 128'h0000_BB00);
      beat(2'b10, 10'd0, 10'd200, rnd64(), rnd64(), 1'b0, "r36_oob");
      chk("r36_idx_err", 128'(idx_err), 128'(1));
      chk("r36_unchanged", vd_out, 128'h0000_BB00);
      beat(2'b00, 10'd0, 10'd0, rnd64(), rnd64(), 1'b1, "r36_done");
      release_wb("r36_release");
      do_start(3'd0, '0, "r36_err_clear");
      chk("r36_err_cleared", 128'(idx_err), 128'(0));
      beat(2'b00, 10'd0, 10'd0, '0, '0, 1'b1, "r36_done2");
      release_wb("r36_release2");

      // Write-back stall with start and lane strobes active
      do_start(3'd2, {$urandom, $urandom, $urandom, $urandom}, "r37_start");
      beat(2'b11, 10'd0, 10'd96, rnd64(), rnd64(), 1'b1, "r37_beat");
      saved = vd_out;
      for (int i = 0; i < 3; i++) begin
         start      = 1'b1;
         lane_valid = 2'b11;
         lane_idx   = {10'd0, 10'd0};
         lane_vd    = {rnd64(), rnd64()};
         vd_old     = {$urandom, $urandom, $urandom, $urandom};
         alu_done   = 1'b1;
         wb_ready   = 1'b0;
         cyc("r37_hold");
         chk("r37_stable", vd_out, saved);
      end
      release_wb("r37_release");
      chk("r37_idle", 128'(busy), 128'(0));

      // Random transactions
      for (int t = 0; t < 25; t++) begin
         quiet();
         lane_valid = 2'($urandom);
         alu_done   = 1'($urandom);
         wb_ready   = 1'($urandom);
         cyc("rnd_idle");
         do_start(3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom}, "rnd_start");
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            beat(2'($urandom), 10'($urandom_range(0, 140)), 10'($urandom_range(0, 140)),
                 rnd64(), rnd64(), (b == nb - 1), "rnd_beat");
            if (($urandom % 8) == 0 && m_st == 1) begin
               start    = 1'b1;
               vd_old   = {$urandom, $urandom, $urandom, $urandom};
               alu_done = 1'($urandom);
               cyc("rnd_restart");
               start    = 1'b0;
            end
         end
         for (int g = 0; g < 4 && m_st == 1; g++) begin
            beat(2'($urandom), 10'($urandom_range(100, 135)), 10'($urandom_range(0, 127)),
                 rnd64(), rnd64(), 1'b1, "rnd_finish");
         end
         for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
            start      = 1'($urandom);
            lane_valid = 2'($urandom);
            wb_ready   = 1'b0;
            cyc("rnd_stall");
         end
         release_wb("rnd_release");
      end

      // Asynchronous reset in the middle of collection
      do_start(3'd3, '1, "r38_start");
      beat(2'b01, 10'd0, 10'd0, rnd64(), rnd64(), 1'b0, "r38_beat");
      #2;
      resetn = 1'b0;
      #1;
      m_st = 0; m_buf = '0; m_err = 1'b0;
      chk_all("r38_async_collect");

      // First start after reset release is taken on the first edge
      @(posedge clk);
      #1;
      resetn = 1'b1;
      do_start(3'd0, {$urandom, $urandom, $urandom, $urandom}, "r32_first_start");
      chk("r32_busy", 128'(busy), 128'(1));
      beat(2'b11, 10'd120, 10'd124, rnd64(), rnd64(), 1'b1, "r32_beat");

      // Asynchronous reset while waiting in write-back
      #2;
      resetn = 1'b0;
      #1;
      m_st = 0; m_buf = '0; m_err = 1'b0;
      chk_all("r38_async_wb");
      @(posedge clk);
      #1;
      resetn = 1'b1;
      quiet();
      cyc("post_reset_idle");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
